// File: rtl/core_mem_multi.sv
// Multi-port core memory mock: NUM_PORTS req/gnt/rvalid ports on one shared word array with fixed
// response latency. Define CORE_MEM_MULTI_RANDOM_STALL_EN to add LFSR-driven grant stalls.
module core_mem_multi #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned MEM_ADDR_BITS   = 16,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_PORTS-1:0]               req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]               we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [CNT_W-1:0]         r_cnt [NUM_PORTS];
  logic [LATENCY-1:0]       r_vld [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    r_dat [NUM_PORTS][LATENCY];

  logic [MEM_ADDR_BITS-1:0] w_idx [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    w_rd  [NUM_PORTS];
  logic [NUM_PORTS-1:0]     w_room;
  logic [NUM_PORTS-1:0]     w_stall;
  logic                     w_unused_addr;

  // Address bits outside the word index are ignored, so addresses alias.
  assign w_unused_addr = ^addr_i;

`ifdef CORE_MEM_MULTI_RANDOM_STALL_EN
  logic [15:0] r_lfsr [NUM_PORTS];

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_lfsr[p] <= 16'hACE1 + 16'(p);
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_lfsr[p] <= {1'b0, r_lfsr[p][15:1]} ^ (r_lfsr[p][0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  always_comb begin
    w_stall = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_stall[p] = (r_lfsr[p][1:0] == 2'b00);
    end
  end
`else
  assign w_stall = '0;
`endif

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    w_room   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_idx[p]    = addr_i[p*ADDR_WIDTH+OFF +: MEM_ADDR_BITS];
      // Sampled before this cycle's writes land: read-before-write.
      w_rd[p]     = we_i[p] ? '0 : r_mem[w_idx[p]];
      rvalid_o[p] = r_vld[p][LATENCY-1];
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_dat[p][LATENCY-1];
      // A slot retiring this cycle can be handed straight to a new request.
      w_room[p]   = (r_cnt[p] < CNT_W'(MAX_OUTSTANDING)) | rvalid_o[p];
      gnt_o[p]    = req_i[p] & w_room[p] & ~w_stall[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_cnt[p] <= '0;
        r_vld[p] <= '0;
        for (int unsigned s = 0; s < LATENCY; s++) begin
          r_dat[p][s] <= '0;
        end
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (gnt_o[p] && !rvalid_o[p]) begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end else if (!gnt_o[p] && rvalid_o[p]) begin
          r_cnt[p] <= r_cnt[p] - 1'b1;
        end
        r_vld[p][0] <= gnt_o[p];
        r_dat[p][0] <= gnt_o[p] ? w_rd[p] : '0;
        for (int unsigned s = 1; s < LATENCY; s++) begin
          r_vld[p][s] <= r_vld[p][s-1];
          r_dat[p][s] <= r_dat[p][s-1];
        end
      end
    end
  end

  // Later ports override earlier ones per byte, so the highest port index wins collisions.
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (gnt_o[p] && we_i[p] && be_i[p*NB+b]) begin
          r_mem[w_idx[p]][b*8 +: 8] <= wdata_i[p*DATA_WIDTH+b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_multi.sv
// Bench for core_mem_multi: two instances (LATENCY 1 and 3) driven by the same directed and random
// stimulus, checked against a queue-based reference model of grants, responses and memory.
module tb_core_mem_multi;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = '0;
  logic [1:0]   we = '0;
  logic [127:0] addr = '0;
  logic [15:0]  be = '0;
  logic [127:0] wdata = '0;
  logic [1:0]   gnt1, rv1, gnt3, rv3;
  logic [127:0] rd1, rd3;

  always #5 clk = ~clk;

  core_mem_multi u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1)
  );

  core_mem_multi #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3)
  );

  // Reference model: per-instance word memory and per-port response FIFO of {due cycle, data}.
  logic [63:0] mm [2][65536];
  int          q_due [2][2][8];
  logic [63:0] q_dat [2][2][8];
  int          q_hd [2][2];
  int          q_n [2][2];
  int          lat [2] = '{1, 3};
  int          mx [2] = '{2, 2};
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          stalls = 0;
  int          opps = 0;
  logic [1:0]  s_g1, s_g3, s_rv1, s_rv3;
  logic [127:0] s_rd1, s_rd3;
  logic [6:0]  gpat, rpat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) & 64'hFFFF);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        q_hd[d][p] = 0;
        q_n[d][p]  = 0;
      end
    end
  endtask

  task automatic drv(input int p, input bit r, input bit w, input logic [63:0] a,
                     input logic [7:0] b, input logic [63:0] dat);
    req[p] = r;
    we[p] = w;
    addr[p*64 +: 64] = a;
    be[p*8 +: 8] = b;
    wdata[p*64 +: 64] = dat;
  endtask

  task automatic idle();
    req = '0;
    we = '0;
  endtask

  // One clock: sample at the falling edge, check against the model, advance the model.
  task automatic cycle();
    logic [1:0]  g_dut, rv_dut;
    logic [127:0] rd_dut;
    logic        exp_rv, exp_g, allowed;
    logic [1:0]  gx [2];
    logic [63:0] rdx;
    int          slot, ix;
    @(negedge clk);
    s_g1 = gnt1; s_g3 = gnt3; s_rv1 = rv1; s_rv3 = rv3; s_rd1 = rd1; s_rd3 = rd3;
    for (int d = 0; d < 2; d++) begin
      g_dut  = (d == 0) ? gnt1 : gnt3;
      rv_dut = (d == 0) ? rv1 : rv3;
      rd_dut = (d == 0) ? rd1 : rd3;
      gx[d] = '0;
      for (int p = 0; p < 2; p++) begin
        exp_rv  = (q_n[d][p] > 0) && (q_due[d][p][q_hd[d][p]] == cyc);
        allowed = req[p] && ((q_n[d][p] < mx[d]) || exp_rv);
`ifdef CORE_MEM_MULTI_RANDOM_STALL_EN
        if (allowed) begin
          opps++;
          if (!g_dut[p]) stalls++;
        end
        exp_g = allowed & g_dut[p];
`else
        exp_g = allowed;
`endif
        chk($sformatf("gnt d%0d p%0d c%0d", d, p, cyc), 64'(g_dut[p]), 64'(exp_g));
        chk($sformatf("rvalid d%0d p%0d c%0d", d, p, cyc), 64'(rv_dut[p]), 64'(exp_rv));
        if (exp_rv) begin
          chk($sformatf("rdata d%0d p%0d c%0d", d, p, cyc), rd_dut[p*64 +: 64],
              q_dat[d][p][q_hd[d][p]]);
          q_hd[d][p] = (q_hd[d][p] + 1) % 8;
          q_n[d][p]--;
        end
        if (exp_g) begin
          gx[d][p] = 1'b1;
          rdx  = we[p] ? 64'h0 : mm[d][widx(addr[p*64 +: 64])];
          slot = (q_hd[d][p] + q_n[d][p]) % 8;
          q_due[d][p][slot] = cyc + lat[d];
          q_dat[d][p][slot] = rdx;
          q_n[d][p]++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (gx[d][p] && we[p]) begin
          ix = widx(addr[p*64 +: 64]);
          for (int b = 0; b < 8; b++) begin
            if (be[p*8+b]) mm[d][ix][b*8 +: 8] = wdata[p*64+b*8 +: 8];
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) cycle();
  endtask

  initial begin
    logic [63:0] v, a;
    clear_model();
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      mm[0][i] = v; mm[1][i] = v;
      u_d1.r_mem[i] = v; u_d3.r_mem[i] = v;
    end
    mm[0][8] = 64'h5; mm[1][8] = 64'h5; u_d1.r_mem[8] = 64'h5; u_d3.r_mem[8] = 64'h5;
    mm[0][32] = '0; mm[1][32] = '0; u_d1.r_mem[32] = '0; u_d3.r_mem[32] = '0;

    // Reset state, and grant following req while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv1", 64'(rv1), 64'h0);
    chk("rst_rd1", rd1[63:0] | rd1[127:64], 64'h0);
    chk("rst_rv3", 64'(rv3), 64'h0);
    chk("rst_rd3", rd3[63:0] | rd3[127:64], 64'h0);
    req = 2'b11;
    #1;
    chk("rst_gnt1", 64'(gnt1), 64'h3);
    chk("rst_gnt3", 64'(gnt3), 64'h3);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read on port 0.
    drv(0, 1, 1, 64'h1000, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t1_wr_gnt", 64'(s_g1[0]), 64'h1);
`endif
    drv(0, 1, 0, 64'h1000, 8'h00, 64'h0);
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t1_rd_gnt", 64'(s_g1[0]), 64'h1);
    chk("t1_wr_rvalid", 64'(s_rv1[0]), 64'h1);
    chk("t1_wr_rdata", s_rd1[63:0], 64'h0);
`endif
    idle();
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t1_rd_rvalid", 64'(s_rv1[0]), 64'h1);
    chk("t1_rd_rdata", s_rd1[63:0], 64'hDEADBEEF_CAFEF00D);
`endif
    drain();

    // Outstanding limit on the LATENCY=3 instance, port 1.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drv(1, 1, 0, 64'h8, 8'h00, 64'h0);
      else idle();
      cycle();
      gpat[k] = s_g3[1];
      rpat[k] = s_rv3[1];
    end
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t2_gnt_pattern", 64'(gpat), 64'(7'b0001011));
    chk("t2_rvalid_pattern", 64'(rpat), 64'(7'b1011000));
`endif
    drain();

    // Same-cycle byte-merged writes to one word, highest port wins.
    drv(0, 1, 1, 64'h100, 8'h0F, 64'h11111111_11111111);
    drv(1, 1, 1, 64'h100, 8'h3C, 64'h22222222_22222222);
    cycle();
    idle();
    drain();
    drv(0, 1, 0, 64'h100, 8'h00, 64'h0);
    cycle();
    idle();
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t3_merge", s_rd1[63:0], 64'h00002222_22221111);
`endif
    drain();

    // Read-before-write between ports.
    drv(0, 1, 0, 64'h40, 8'h00, 64'h0);
    drv(1, 1, 1, 64'h40, 8'hFF, 64'h0000ABCD_00000123);
    cycle();
    idle();
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t4_old", s_rd1[63:0], 64'h5);
`endif
    drain();
    drv(0, 1, 0, 64'h40, 8'h00, 64'h0);
    cycle();
    idle();
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t4_new", s_rd1[63:0], 64'h0000ABCD_00000123);
`endif
    drain();

    // Reset with responses in flight.
    drv(0, 1, 0, 64'h10, 8'h00, 64'h0);
    cycle();
    cycle();
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_rv1", 64'(rv1), 64'h0);
    chk("t5_rv3", 64'(rv3), 64'h0);
    chk("t5_rd3", rd3[63:0], 64'h0);
    chk("t5_cnt3", 64'(u_d3.r_cnt[0]), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rv3_held", 64'(rv3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    repeat (4) cycle();
    drv(0, 1, 0, 64'h10, 8'h00, 64'h0);
    cycle();
`ifndef CORE_MEM_MULTI_RANDOM_STALL_EN
    chk("t5_first_gnt3", 64'(s_g3[0]), 64'h1);
`endif
    drain();

    // Random traffic with address aliasing over a 16-word window.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 2; p++) begin
        a = ({$urandom, $urandom} & ~64'h7FFFF) | (64'($urandom_range(0, 15)) << 3) |
            64'($urandom_range(0, 7));
        drv(p, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a, 8'($urandom),
            {$urandom, $urandom});
      end
      cycle();
    end
    drain();

`ifdef CORE_MEM_MULTI_RANDOM_STALL_EN
    total++;
    assert ((stalls * 100 >= opps * 20) && (stalls * 100 <= opps * 30)) else begin
      bad++;
      $error("FAIL stall_ratio observed=%0d/%0d expected=20..30 percent", stalls, opps);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
